// File: rtl/ram_scan_rd.sv
// ram_scan_rd: sweeps a RAM address window with 1-cycle-latency reads and streams the
// returned words downstream through a small address-tagged FIFO. Define SCAN_MAX_TRACK_EN
// to add max_data/max_addr tracking of the largest word handed downstream.
module ram_scan_rd #(
   parameter int ADDR_LEN   = 16,
   parameter int DATA_LEN   = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic                start,
   input  logic [ADDR_LEN-1:0] base_addr,
   input  logic [ADDR_LEN:0]   length,
   output logic                rd_en,
   output logic [ADDR_LEN-1:0] rd_addr,
   input  logic [DATA_LEN-1:0] rd_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_LEN-1:0] out_data,
   output logic [ADDR_LEN-1:0] out_addr,
   output logic                out_last,
   output logic                busy,
   output logic                done
`ifdef SCAN_MAX_TRACK_EN
   ,
   output logic [DATA_LEN-1:0] max_data,
   output logic [ADDR_LEN-1:0] max_addr
`endif
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_V = (CW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   typedef struct packed {
      logic                last;
      logic [ADDR_LEN-1:0] addr;
      logic [DATA_LEN-1:0] data;
   } entry_t;

   state_t              state_q, state_d;
   logic [ADDR_LEN-1:0] addr_q, addr_d;
   logic [ADDR_LEN:0]   rem_q, rem_d;
   logic                infl_q, infl_d;
   logic [ADDR_LEN-1:0] infl_addr_q, infl_addr_d;
   logic                infl_last_q, infl_last_d;
   logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   entry_t              mem_q [FIFO_DEPTH];
   entry_t              mem_d [FIFO_DEPTH];
   logic [DATA_LEN-1:0] max_data_q, max_data_d;
   logic [ADDR_LEN-1:0] max_addr_q, max_addr_d;

   entry_t      head_s;
   logic        valid_s;
   logic        pop_s;
   logic        issue_s;
   logic [CW:0] occ_s;

   assign head_s  = mem_q[rd_ptr_q];
   assign valid_s = (cnt_q != '0);
   assign pop_s   = valid_s && out_ready;
   // Occupancy counts the in-flight read so a returning word always has a slot.
   assign occ_s   = {1'b0, cnt_q} + (CW+1)'(infl_q) - (CW+1)'(pop_s);
   assign issue_s = (state_q == S_RUN) && (rem_q != '0) && (occ_s < DEPTH_V);

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      rem_d       = rem_q;
      infl_d      = issue_s;
      infl_addr_d = infl_addr_q;
      infl_last_d = infl_last_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      mem_d       = mem_q;
      max_data_d  = max_data_q;
      max_addr_d  = max_addr_q;

      if (infl_q) begin
         mem_d[wr_ptr_q] = '{last: infl_last_q, addr: infl_addr_q, data: rd_data};
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      cnt_d = cnt_q + CW'(infl_q) - CW'(pop_s);

      if (pop_s && (head_s.data > max_data_q)) begin
         max_data_d = head_s.data;
         max_addr_d = head_s.addr;
      end else begin
         max_data_d = max_data_q;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d     = base_addr;
               rem_d      = length;
               wr_ptr_d   = '0;
               rd_ptr_d   = '0;
               cnt_d      = '0;
               max_data_d = '0;
               max_addr_d = '0;
               state_d    = (length != '0) ? S_RUN : S_DONE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            if (issue_s) begin
               addr_d      = addr_q + ADDR_LEN'(1);
               rem_d       = rem_q - (ADDR_LEN+1)'(1);
               infl_addr_d = addr_q;
               infl_last_d = (rem_q == (ADDR_LEN+1)'(1));
               state_d     = (rem_q == (ADDR_LEN+1)'(1)) ? S_DRAIN : S_RUN;
            end else begin
               state_d = S_RUN;
            end
         end
         S_DRAIN: begin
            if (pop_s && head_s.last) begin
               state_d = S_DONE;
            end else begin
               state_d = S_DRAIN;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         rem_q       <= '0;
         infl_q      <= 1'b0;
         infl_addr_q <= '0;
         infl_last_q <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         max_data_q  <= '0;
         max_addr_q  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         rem_q       <= rem_d;
         infl_q      <= infl_d;
         infl_addr_q <= infl_addr_d;
         infl_last_q <= infl_last_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         max_data_q  <= max_data_d;
         max_addr_q  <= max_addr_d;
         mem_q       <= mem_d;
      end
   end

   assign rd_en     = issue_s;
   assign rd_addr   = addr_q;
   assign out_valid = valid_s;
   assign out_data  = head_s.data;
   assign out_addr  = head_s.addr;
   assign out_last  = head_s.last;
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
`ifdef SCAN_MAX_TRACK_EN
   assign max_data  = max_data_q;
   assign max_addr  = max_addr_q;
`endif

endmodule

// File: tb/tb_ram_scan_rd.sv
// Scoreboard bench for ram_scan_rd: expected addresses/words queued at start, compared as
// the DUT issues reads and hands words downstream. Max checks run when SCAN_MAX_TRACK_EN is set.
module tb_ram_scan_rd;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] base_addr = 16'h0000;
   logic [16:0] length = 17'd0;
   logic        rd_en;
   logic [15:0] rd_addr;
   logic [7:0]  rd_data = 8'h00;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [7:0]  out_data;
   logic [15:0] out_addr;
   logic        out_last;
   logic        busy;
   logic        done;
`ifdef SCAN_MAX_TRACK_EN
   logic [7:0]  max_data;
   logic [15:0] max_addr;
   logic [7:0]  max_data_at_done = 8'h00;
   logic [15:0] max_addr_at_done = 16'h0000;
`endif

   ram_scan_rd #(.ADDR_LEN(16), .DATA_LEN(8), .FIFO_DEPTH(DEPTH)) dut (
      .CLK(clk), .RST_N(rst_n), .start(start), .base_addr(base_addr), .length(length),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_addr(out_addr), .out_last(out_last), .busy(busy), .done(done)
`ifdef SCAN_MAX_TRACK_EN
      , .max_data(max_data), .max_addr(max_addr)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   int t_start = 0;
   int first_rd = -1, last_rd = -1, first_valid = -1, done_cyc = -1;
   int rd_cnt = 0, valid_cnt = 0, busy_cnt = 0, done_cnt = 0;
   int issued = 0, popped = 0;
   logic [15:0] iss_q[$];
   logic [24:0] sb_q[$];
   logic        stall_prev = 1'b0;
   logic [24:0] held_word = 25'd0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [7:0] ram_word(input logic [15:0] a);
      case (a)
         16'h0020: return 8'd3;
         16'h0021: return 8'd9;
         16'h0022: return 8'd9;
         16'h0023: return 8'd2;
         default:  return a[7:0];
      endcase
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // RAM model: one-cycle read latency
   always @(posedge clk) begin
      if (rd_en) rd_data <= ram_word(rd_addr);
   end

   always @(negedge clk) begin
      logic        pop;
      logic [24:0] w;
      pop = out_valid && out_ready;
      w   = {out_last, out_addr, out_data};
      if (rst_n) begin
         if (rd_en) begin
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
            rd_cnt++;
            check_eq("occupancy_lt_depth", 32'((issued - popped - int'(pop)) < DEPTH), 32'd1);
            issued++;
            if (iss_q.size() == 0) check_eq("extra_rd", 32'd1, 32'd0);
            else check_eq("rd_addr", 32'(rd_addr), 32'(iss_q.pop_front()));
         end
         if (out_valid) begin
            if (first_valid < 0) first_valid = cyc;
            valid_cnt++;
         end
         if (stall_prev) begin
            check_eq("stall_valid", 32'(out_valid), 32'd1);
            check_eq("stall_word", 32'(w), 32'(held_word));
         end
         if (pop) begin
            popped++;
            if (sb_q.size() == 0) check_eq("extra_out", 32'd1, 32'd0);
            else check_eq("out_word", 32'(w), 32'(sb_q.pop_front()));
         end
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
`ifdef SCAN_MAX_TRACK_EN
            max_data_at_done = max_data;
            max_addr_at_done = max_addr;
`endif
         end
         stall_prev = out_valid && !out_ready;
         held_word  = w;
      end else begin
         stall_prev = 1'b0;
      end
   end

   task automatic clear_stats();
      first_rd = -1; last_rd = -1; first_valid = -1; done_cyc = -1;
      rd_cnt = 0; valid_cnt = 0; busy_cnt = 0;
   endtask

   task automatic do_start(input logic [15:0] base, input int len, input bit expect_run);
      @(posedge clk); #1;
      if (expect_run) begin
         clear_stats();
         issued = 0;
         popped = 0;
         for (int i = 0; i < len; i++) begin
            logic [15:0] a;
            a = base + 16'(i);
            iss_q.push_back(a);
            sb_q.push_back({(i == len - 1), a, ram_word(a)});
         end
         t_start = cyc;
      end
      start = 1'b1; base_addr = base; length = 17'(len);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run_until_done(input int budget, input bit toggle);
      int k;
      int d0;
      k  = 0;
      d0 = done_cnt;
      while (done_cnt == d0 && k < budget) begin
         if (toggle) out_ready = ((k % 4) == 0) || ((k % 4) == 3);
         @(posedge clk); #1;
         k++;
      end
      if (done_cnt == d0) check_eq("done_timeout", 32'd0, 32'd1);
      out_ready = 1'b1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_rd_en"}, 32'(rd_en), 32'd0);
      check_eq({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
      check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check_eq({tag, "_out_data"}, 32'(out_data), 32'd0);
      check_eq({tag, "_out_addr"}, 32'(out_addr), 32'd0);
      check_eq({tag, "_out_last"}, 32'(out_last), 32'd0);
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
      check_eq({tag, "_done"}, 32'(done), 32'd0);
`ifdef SCAN_MAX_TRACK_EN
      check_eq({tag, "_max_data"}, 32'(max_data), 32'd0);
      check_eq({tag, "_max_addr"}, 32'(max_addr), 32'd0);
`endif
   endtask

   task automatic check_basic_timing(input string tag);
      check_eq({tag, "_first_rd"}, 32'(first_rd - t_start), 32'd1);
      check_eq({tag, "_rd_run"}, 32'(last_rd - first_rd), 32'd3);
      check_eq({tag, "_rd_cnt"}, 32'(rd_cnt), 32'd4);
      check_eq({tag, "_first_valid"}, 32'(first_valid - t_start), 32'd3);
      check_eq({tag, "_valid_cnt"}, 32'(valid_cnt), 32'd4);
      check_eq({tag, "_done_at"}, 32'(done_cyc - t_start), 32'd7);
      check_eq({tag, "_busy_cnt"}, 32'(busy_cnt), 32'd7);
      check_eq({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
   endtask

   initial begin
      int d0;
      int k;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // basic sweep, full throughput
      do_start(16'h0010, 4, 1'b1);
      run_until_done(40, 1'b0);
      check_basic_timing("basic");

      // same sweep under 1,0,0,1 backpressure
      d0 = done_cnt;
      do_start(16'h0010, 4, 1'b1);
      run_until_done(80, 1'b1);
      check_eq("stall_rd_cnt", 32'(rd_cnt), 32'd4);
      check_eq("stall_sb_empty", 32'(sb_q.size()), 32'd0);
      check_eq("stall_done_once", 32'(done_cnt - d0), 32'd1);

      // address wrap
      do_start(16'hFFFE, 4, 1'b1);
      run_until_done(40, 1'b0);
      check_basic_timing("wrap");

      // zero length
      do_start(16'h0050, 0, 1'b1);
      run_until_done(20, 1'b0);
      check_eq("len0_done_at", 32'(done_cyc - t_start), 32'd1);
      check_eq("len0_busy_cnt", 32'(busy_cnt), 32'd1);
      check_eq("len0_rd_cnt", 32'(rd_cnt), 32'd0);
      check_eq("len0_valid_cnt", 32'(valid_cnt), 32'd0);

      // start pulsed mid-sweep is ignored
      d0 = done_cnt;
      do_start(16'h0030, 4, 1'b1);
      do_start(16'h0080, 2, 1'b0);
      run_until_done(40, 1'b0);
      repeat (6) @(posedge clk);
      #1;
      check_eq("ign_rd_cnt", 32'(rd_cnt), 32'd4);
      check_eq("ign_done_once", 32'(done_cnt - d0), 32'd1);
      check_eq("ign_sb_empty", 32'(sb_q.size()), 32'd0);

      // reset one cycle after the second word of an 8-word sweep
      do_start(16'h0040, 8, 1'b1);
      k = 0;
      while (popped < 2 && k < 50) begin
         @(posedge clk);
         k++;
      end
      check_eq("rst_reached_2", 32'(popped >= 2), 32'd1);
      #1;
      rst_n = 1'b0;
      out_ready = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      iss_q.delete();
      sb_q.delete();
      issued = 0;
      popped = 0;
      clear_stats();
      @(negedge clk);
      check_reset_outputs("midrst");
      repeat (8) @(posedge clk);
      #1;
      check_eq("midrst_no_valid", 32'(valid_cnt), 32'd0);
      check_eq("midrst_no_rd", 32'(rd_cnt), 32'd0);
      do_start(16'h0010, 4, 1'b1);
      run_until_done(40, 1'b0);
      check_basic_timing("after_rst");

      // max tracking data 3,9,9,2
      do_start(16'h0020, 4, 1'b1);
      run_until_done(40, 1'b0);
      check_basic_timing("max");
`ifdef SCAN_MAX_TRACK_EN
      check_eq("max_data", 32'(max_data_at_done), 32'd9);
      check_eq("max_addr", 32'(max_addr_at_done), 32'h21);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/ram_scan_rd.md
# ram_scan_rd

Read-side streaming engine for the match-length RAM. On `start`, it sweeps a window of RAM addresses, issues one-cycle-latency reads, and buffers the returned words in a small FIFO. It presents them downstream as an address-tagged valid/ready stream. It sits opposite the RAM write controller: the controller fills and clears the RAM, and this block drains it for readout and back-tracking consumers.

## Interface
- `ADDR_LEN`, 16, RAM address width
- `DATA_LEN`, 8, RAM data width
- `FIFO_DEPTH`, 4, output buffer entries; power of two, minimum 2

- `CLK`  in  1  clock; all state updates on the rising edge
- `RST_N`  in  1  reset, synchronous, active-low
- `start`  in  1  begin a sweep; sampled only in IDLE
- `base_addr`  in  ADDR_LEN  first address; latched on accepted `start`
- `length`  in  ADDR_LEN+1  word count; latched on accepted `start`
- `rd_en`  out  1  RAM read strobe
- `rd_addr`  out  ADDR_LEN  RAM read address
- `rd_data`  in  DATA_LEN  RAM read data; valid exactly 1 cycle after `rd_en`
- `out_valid`  out  1  stream word available
- `out_ready`  in  1  downstream accepts
- `out_data`  out  DATA_LEN  word
- `out_addr`  out  ADDR_LEN  RAM address the word came from
- `out_last`  out  1  final word of the sweep; qualified by `out_valid`
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at sweep end

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: if `start` is high, latch `base_addr`/`length`, clear the FIFO and issue counters, then go to
  - RUN if `length` is nonzero;
  - DONE if `length` is 0 (no reads issued).
- RUN: issue a read (`rd_en`=1, `rd_addr`=current address) when remaining > 0 and `fifo_count + inflight - pop < FIFO_DEPTH`.
  - `pop` is an out handshake in the same cycle.
  - Each issue increments the address modulo 2^ADDR_LEN (0xFFFF wraps to 0x0000) and decrements remaining.
  - Leave for DRAIN in the cycle after the final issue.
- DRAIN: no reads. Go to DONE after the handshake of the word carrying `out_last`.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `start` outside IDLE is ignored; a sweep is never restarted or extended.
- Returned data is pushed into the FIFO tagged with its issuing address. `inflight` is the count of issued-but-not-returned reads (0 or 1).
- `out_last` is set on the entry whose address is the final issued address.
- Backpressure: with `out_ready` low, the FIFO fills, issue stops, and no word is lost or duplicated. `out_data`/`out_addr`/`out_last` stay stable while `out_valid`=1 and `out_ready`=0.
- Reset, including mid-sweep: next state is IDLE, FIFO emptied, and any in-flight read data is discarded.

## Timing
- Reset values: `rd_en`=0, `rd_addr`=0, `out_valid`=0, `out_data`=0, `out_addr`=0, `out_last`=0, `busy`=0, `done`=0.
- `start` accepted in cycle t:
  - first `rd_en` in t+1;
  - `rd_data` captured at the end of t+2;
  - first `out_valid` in t+3.
- Throughput: 1 word/cycle with `out_ready` held high. `rd_en` is continuous for `length` cycles.
- `done` occurs the cycle after the final handshake.
  - Sweep of N words with `out_ready`=1: `done` at t+N+3.
  - `length`=0: `done` at t+1.
- All outputs are registered; there is no combinational path from `out_ready` to `out_valid`. `rd_en` depends on registered state plus the current `out_ready`.

## Configuration
- `SCAN_MAX_TRACK_EN` defined: adds outputs `max_data` (DATA_LEN) and `max_addr` (ADDR_LEN).
  - Both are cleared to 0 on accepted `start` and on reset.
  - Updated on each out handshake when `out_data` > `max_data` (strictly greater, so the first occurrence wins ties).
  - Final values are valid when `done`=1 and held until the next `start`.
- Undefined: the ports and logic are absent; the rest of the behaviour is identical.

## Test plan
- `base_addr`=0x0010, `length`=4, RAM[a]=a[7:0], `out_ready`=1.
  - Expect `rd_addr` 0x10..0x13 in t+1..t+4.
  - Expect out words 0x10..0x13 in t+3..t+6, `out_last` on 0x13, `done` at t+7.
- Same sweep with `out_ready` toggling 1,0,0,1,… → the same 4 words in order with no duplicates, data held stable while stalled, and `rd_en` never asserted while FIFO plus in-flight reads already hold `FIFO_DEPTH`.
- `base_addr`=0xFFFE, `length`=4 → `rd_addr` sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001, with `out_addr` matching.
- `length`=0 → no `rd_en`, no `out_valid`, `busy` high 1 cycle, `done` at t+1; a `start` pulsed during a sweep is ignored.
- `RST_N`=0 for 1 cycle after the second word of an 8-word sweep → all outputs at reset values the next cycle and no further out words; a new `start` runs a clean sweep.
- With `SCAN_MAX_TRACK_EN`: data 3, 9, 9, 2 at 0x20..0x23 → `max_data`=9, `max_addr`=0x21 at `done`.
